sine_phase_rx: RTL and testbench
================================

# sine_phase_rx

Receive-side companion to the 32-entry sine lookup: takes a stream of 8-bit sine samples (the same quantised table, amplitude 0..200, centre 100, period 32) and recovers the 5-bit phase index that produced each sample. A lock state machine tracks index progression and flags loss of lock. It sits at the sink end of the sine sample path, for loopback checking and phase recovery.

## Interface
- LOCK_CNT, 4: consecutive +1 index steps needed in ACQUIRE to enter LOCKED (1..15).
- MISS_MAX, 2: consecutive mismatches in LOCKED that drop lock (1..7).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input ready; s_ready = !m_valid || m_ready (combinational).
- s_data  in  8  input sample, unsigned 0..200.
- m_valid  out  1  output phase valid.
- m_ready  in  1  downstream ready.
- m_phase  out  5  recovered phase index.
- m_locked  out  1  state is LOCKED at the time the sample was decoded.
- m_err  out  1  one-output pulse: this output caused the LOCKED to ACQUIRE drop.

## Operation
- Accept when s_valid && s_ready. Output held stable while m_valid && !m_ready.
- Magnitude: d = |s_data - 100|. Values > 200 are saturated to 200.
- Quarter index q (0..8): number of thresholds {10,29,47,63,77,88,95,99} with d >= threshold.
- Slope: rising if s_data > prev, falling if s_data < prev. If equal, reuse the previous slope.
- Decoded index:
  - s >= 100 and rising: q.
  - s >= 100 and falling: 16 - q.
  - s < 100 and falling: 16 + q.
  - s < 100 and rising: (32 - q) mod 32.
- States:
  - SEARCH: the accepted sample is stored as prev and slope is set to rising. No output. Go to ACQUIRE.
  - ACQUIRE: emit the decoded index with m_locked=0.
    - If decoded == (last_idx + 1) mod 32, increment the match count; otherwise reset it to 0.
    - When the count reaches LOCK_CNT, go to LOCKED. The output for that sample still carries m_locked=0.
  - LOCKED: predicted = (last_idx + 1) mod 32. Emit with m_locked=1.
    - A mismatch (decoded != predicted) increments the miss count; a match clears it.
    - When misses reach MISS_MAX, emit with m_err=1 and m_locked=1, go to ACQUIRE, and clear both counts.
- last_idx is updated to the emitted index on every emitted output.
- prev is updated to s_data on every accepted sample.
- Index arithmetic is 5-bit modulo 32; 31 → 0 is a valid +1 step.

## Timing
- Latency: 1 cycle. A sample accepted on edge N appears on m_* after edge N.
- Throughput: one sample per cycle while m_ready=1.
- Back-pressure: with m_valid && !m_ready, s_ready=0. No input is accepted and no state advances.
- Simultaneous events: if m_ready and s_valid arrive in the same cycle, the output is consumed and a new one is loaded on the same edge.
- Reset, asynchronous at any time, including mid-stream with m_valid=1:
  - state=SEARCH, all counts 0, prev=100, last_idx=0, slope=rising.
  - m_valid=0, m_phase=0, m_locked=0, m_err=0.
  - The pending output is discarded.
  - s_ready=1 during and after reset.

## Configuration
- SINE_PHASE_RX_FLYWHEEL_EN defined: in LOCKED, m_phase is the predicted index. A single corrupted sample therefore does not disturb the output sequence.
- Not defined: m_phase is always the decoded index. Lock and miss tracking are unchanged.

## Test plan
- Clean sweep: reset, then feed table samples for indices 0..40 (100,119,138,155,170,...). Required response:
  - First sample gives no output.
  - Outputs m_phase = 1,2,3,... with m_locked=0 on the first 4 outputs (LOCK_CNT=4), then m_locked=1.
  - Wrap 31 → 0 occurs without error.
- Falling and lower half: start mid-cycle at index 12 (170,155,138,...). Required response:
  - Indices 13..31 are recovered correctly, including 24 (s=0, q=8) and 28 (s=29, falling-to-rising region).
- Glitch in LOCKED with flywheel: replace the index-20 sample (29) with 200. Required response:
  - With SINE_PHASE_RX_FLYWHEEL_EN: m_phase=20, still locked, no m_err.
  - Without it: m_phase=8.
- Lock loss: in LOCKED, feed 2 consecutive wrong samples (MISS_MAX=2). Required response:
  - Second output has m_err=1.
  - Following outputs have m_locked=0 until 4 further matches.
- Back-pressure: hold m_ready=0 for 5 cycles mid-stream. Required response:
  - m_valid and m_phase are held, s_ready=0, no samples are lost.
  - After release, the sequence continues with the next index.
- Reset mid-stream: assert rst while m_valid=1 and LOCKED. Required response:
  - Outputs go to 0 immediately (asynchronous).
  - After release, the first sample gives no output (SEARCH).

Source files
------------

// File: rtl/sine_phase_rx.sv
// sine_phase_rx: sink-side phase recovery for the 32-entry quantised sine
// stream (amplitude 0..200, centre 100). Each accepted 8-bit sample is mapped
// back to its 5-bit table index from its distance to the centre line, which
// half it sits in and whether the waveform is rising or falling. A
// SEARCH/ACQUIRE/LOCKED state machine tracks +1 index progression.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The source holds data stable while valid is high and ready is
// low. s_ready = !m_valid || m_ready, so the single output register can be
// drained and refilled on the same edge.
//
// Optional build macro SINE_PHASE_RX_FLYWHEEL_EN: while LOCKED, m_phase
// carries the predicted index instead of the decoded one, so a lone corrupted
// sample does not disturb the output sequence.
module sine_phase_rx #(
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [4:0] m_phase,
    output logic       m_locked,
    output logic       m_err
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [2:0] MISS_TGT = 3'(MISS_MAX);

    state_t     state;
    logic [7:0] prev;
    logic       slope_rising;
    logic [4:0] last_idx;
    logic [3:0] match_cnt;
    logic [2:0] miss_cnt;

    logic       accept;
    logic [7:0] sat;
    logic [7:0] mag;
    logic [3:0] quarter;
    logic       upper;
    logic       rising_now;
    logic [4:0] decoded;
    logic [4:0] predicted;
    logic       is_match;
    logic [4:0] locked_phase;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // Decode the incoming sample into a table index and compare with the
    // index expected after the last emitted one.
    always_comb begin
        sat     = (s_data > 8'd200) ? 8'd200 : s_data;
        upper   = (sat >= 8'd100);
        mag     = upper ? (sat - 8'd100) : (8'd100 - sat);

        // Thresholds sit midway between successive quarter-wave magnitudes.
        quarter = 4'd0;
        if (mag >= 8'd10) quarter = quarter + 4'd1;
        if (mag >= 8'd29) quarter = quarter + 4'd1;
        if (mag >= 8'd47) quarter = quarter + 4'd1;
        if (mag >= 8'd63) quarter = quarter + 4'd1;
        if (mag >= 8'd77) quarter = quarter + 4'd1;
        if (mag >= 8'd88) quarter = quarter + 4'd1;
        if (mag >= 8'd95) quarter = quarter + 4'd1;
        if (mag >= 8'd99) quarter = quarter + 4'd1;

        // A flat step (equal samples) keeps the previous slope.
        if (s_data > prev)
            rising_now = 1'b1;
        else if (s_data < prev)
            rising_now = 1'b0;
        else
            rising_now = slope_rising;

        case ({upper, rising_now})
            2'b11:   decoded = {1'b0, quarter};
            2'b10:   decoded = 5'd16 - {1'b0, quarter};
            2'b00:   decoded = 5'd16 + {1'b0, quarter};
            default: decoded = 5'd0 - {1'b0, quarter};
        endcase

        predicted = last_idx + 5'd1;
        is_match  = (decoded == predicted);

`ifdef SINE_PHASE_RX_FLYWHEEL_EN
        locked_phase = predicted;
`else
        locked_phase = decoded;
`endif
    end

    // Lock state machine plus the registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SEARCH;
            prev         <= 8'd100;
            slope_rising <= 1'b1;
            last_idx     <= 5'd0;
            match_cnt    <= 4'd0;
            miss_cnt     <= 3'd0;
            m_valid      <= 1'b0;
            m_phase      <= 5'd0;
            m_locked     <= 1'b0;
            m_err        <= 1'b0;
        end else begin
            // Drain the output register once downstream takes it.
            if (m_valid && m_ready)
                m_valid <= 1'b0;

            if (accept) begin
                prev <= s_data;
                case (state)
                    SEARCH: begin
                        slope_rising <= 1'b1;
                        state        <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        slope_rising <= rising_now;
                        m_valid      <= 1'b1;
                        m_phase      <= decoded;
                        m_locked     <= 1'b0;
                        m_err        <= 1'b0;
                        last_idx     <= decoded;
                        if (is_match) begin
                            if ((match_cnt + 4'd1) == LOCK_TGT) begin
                                match_cnt <= 4'd0;
                                miss_cnt  <= 3'd0;
                                state     <= LOCKED;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end else begin
                            match_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        slope_rising <= rising_now;
                        m_valid      <= 1'b1;
                        m_phase      <= locked_phase;
                        m_locked     <= 1'b1;
                        last_idx     <= locked_phase;
                        if (is_match) begin
                            miss_cnt <= 3'd0;
                            m_err    <= 1'b0;
                        end else if ((miss_cnt + 3'd1) == MISS_TGT) begin
                            m_err     <= 1'b1;
                            miss_cnt  <= 3'd0;
                            match_cnt <= 4'd0;
                            state     <= ACQUIRE;
                        end else begin
                            miss_cnt <= miss_cnt + 3'd1;
                            m_err    <= 1'b0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sine_phase_rx.sv
// Directed testbench for sine_phase_rx (LOCK_CNT=4, MISS_MAX=2).
// Expected phases and flags are hand-derived from the decode rules.
// Table: floor(100 + 100*sin(2*pi*i/32)), except the two trough neighbours
// (indices 23 and 25) which use 2, mirroring the 198 peak neighbours so their
// magnitude (98) stays below the top threshold.
module tb_sine_phase_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] m_phase;
    logic       m_locked;
    logic       m_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] sine_tab [0:31];

    sine_phase_rx #(.LOCK_CNT(4), .MISS_MAX(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_phase  (m_phase),
        .m_locked (m_locked),
        .m_err    (m_err)
    );

    // clock
    always #5 clk = ~clk;

    // drive one sample for one edge, leave outputs ready to sample 1ns later
    task automatic push(input logic [7:0] v);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = v;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_phase !== 5'd0 || m_locked !== 1'b0 || m_err !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_during: got v=%b ph=%0d l=%b e=%b rdy=%b, expected 0 0 0 0 1",
                     m_valid, m_phase, m_locked, m_err, s_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_phase !== 5'd0 || m_locked !== 1'b0 || m_err !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_after: got v=%b ph=%0d l=%b e=%b rdy=%b, expected 0 0 0 0 1",
                     m_valid, m_phase, m_locked, m_err, s_ready);
        end
    endtask

    task automatic test_clean_sweep();
        do_reset();
        push(sine_tab[0]);
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_search: got m_valid=%b, expected 0", m_valid);
        end
        for (int i = 1; i <= 40; i++) begin
            push(sine_tab[i % 32]);
            tests_run++;
            if (m_valid !== 1'b1 || m_phase !== 5'(i % 32) || m_locked !== (i >= 5) || m_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL sweep idx=%0d: got v=%b ph=%0d l=%b e=%b, expected v=1 ph=%0d l=%b e=0",
                         i, m_valid, m_phase, m_locked, m_err, i % 32, (i >= 5));
            end
        end
    endtask

    task automatic test_lower_half();
        do_reset();
        push(sine_tab[12]);
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lower_search: got m_valid=%b, expected 0", m_valid);
        end
        for (int i = 13; i <= 31; i++) begin
            push(sine_tab[i]);
            tests_run++;
            if (m_valid !== 1'b1 || m_phase !== 5'(i) || m_locked !== (i >= 18) || m_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL lower idx=%0d: got v=%b ph=%0d l=%b e=%b, expected v=1 ph=%0d l=%b e=0",
                         i, m_valid, m_phase, m_locked, m_err, i, (i >= 18));
            end
        end
    endtask

    task automatic test_glitch();
        logic [4:0] g_ph;
        logic       el [0:5];
        logic       ee [0:5];
`ifdef SINE_PHASE_RX_FLYWHEEL_EN
        g_ph = 5'd20;
        el   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ee   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        g_ph = 5'd8;
        el   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ee   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        for (int i = 0; i <= 19; i++) push(sine_tab[i]);
        push(8'd200);
        tests_run++;
        if (m_valid !== 1'b1 || m_phase !== g_ph || m_locked !== 1'b1 || m_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch: got v=%b ph=%0d l=%b e=%b, expected v=1 ph=%0d l=1 e=0",
                     m_valid, m_phase, m_locked, m_err, g_ph);
        end
        for (int k = 0; k < 6; k++) begin
            push(sine_tab[21 + k]);
            tests_run++;
            if (m_valid !== 1'b1 || m_phase !== 5'(21 + k) || m_locked !== el[k] || m_err !== ee[k]) begin
                tests_failed++;
                $display("FAIL glitch_after idx=%0d: got v=%b ph=%0d l=%b e=%b, expected v=1 ph=%0d l=%b e=%b",
                         21 + k, m_valid, m_phase, m_locked, m_err, 21 + k, el[k], ee[k]);
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [4:0] w_ph [0:1];
        logic       el [0:6];
`ifdef SINE_PHASE_RX_FLYWHEEL_EN
        w_ph = '{5'd9, 5'd10};
        el   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        w_ph = '{5'd20, 5'd20};
        el   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        for (int i = 0; i <= 8; i++) push(sine_tab[i]);
        push(8'd29);
        tests_run++;
        if (m_valid !== 1'b1 || m_phase !== w_ph[0] || m_locked !== 1'b1 || m_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL loss_miss1: got v=%b ph=%0d l=%b e=%b, expected v=1 ph=%0d l=1 e=0",
                     m_valid, m_phase, m_locked, m_err, w_ph[0]);
        end
        push(8'd29);
        tests_run++;
        if (m_valid !== 1'b1 || m_phase !== w_ph[1] || m_locked !== 1'b1 || m_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL loss_miss2: got v=%b ph=%0d l=%b e=%b, expected v=1 ph=%0d l=1 e=1",
                     m_valid, m_phase, m_locked, m_err, w_ph[1]);
        end
        for (int k = 0; k < 7; k++) begin
            push(sine_tab[21 + k]);
            tests_run++;
            if (m_valid !== 1'b1 || m_phase !== 5'(21 + k) || m_locked !== el[k] || m_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL loss_reacq idx=%0d: got v=%b ph=%0d l=%b e=%b, expected v=1 ph=%0d l=%b e=0",
                         21 + k, m_valid, m_phase, m_locked, m_err, 21 + k, el[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int i = 0; i <= 10; i++) push(sine_tab[i]);
        @(negedge clk);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = sine_tab[11];
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (m_valid !== 1'b1 || m_phase !== 5'd10 || m_locked !== 1'b1 || s_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cyc=%0d: got v=%b ph=%0d l=%b rdy=%b, expected v=1 ph=10 l=1 rdy=0",
                         c, m_valid, m_phase, m_locked, s_ready);
            end
        end
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        tests_run++;
        if (m_valid !== 1'b1 || m_phase !== 5'd11 || m_locked !== 1'b1 || m_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: got v=%b ph=%0d l=%b e=%b, expected v=1 ph=11 l=1 e=0",
                     m_valid, m_phase, m_locked, m_err);
        end
        for (int i = 12; i <= 13; i++) begin
            push(sine_tab[i]);
            tests_run++;
            if (m_valid !== 1'b1 || m_phase !== 5'(i) || m_locked !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_after idx=%0d: got v=%b ph=%0d l=%b, expected v=1 ph=%0d l=1",
                         i, m_valid, m_phase, m_locked, i);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i <= 7; i++) push(sine_tab[i]);
        tests_run++;
        if (m_valid !== 1'b1 || m_phase !== 5'd7 || m_locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre: got v=%b ph=%0d l=%b, expected v=1 ph=7 l=1",
                     m_valid, m_phase, m_locked);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_phase !== 5'd0 || m_locked !== 1'b0 || m_err !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_async: got v=%b ph=%0d l=%b e=%b rdy=%b, expected 0 0 0 0 1",
                     m_valid, m_phase, m_locked, m_err, s_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        push(sine_tab[8]);
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_search: got m_valid=%b, expected 0", m_valid);
        end
        push(sine_tab[9]);
        tests_run++;
        if (m_valid !== 1'b1 || m_phase !== 5'd9 || m_locked !== 1'b0 || m_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_first: got v=%b ph=%0d l=%b e=%b, expected v=1 ph=9 l=0 e=0",
                     m_valid, m_phase, m_locked, m_err);
        end
    endtask

    initial begin
        sine_tab = '{8'd100, 8'd119, 8'd138, 8'd155, 8'd170, 8'd183, 8'd192, 8'd198,
                     8'd200, 8'd198, 8'd192, 8'd183, 8'd170, 8'd155, 8'd138, 8'd119,
                     8'd100, 8'd80,  8'd61,  8'd44,  8'd29,  8'd16,  8'd7,   8'd2,
                     8'd0,   8'd2,   8'd7,   8'd16,  8'd29,  8'd44,  8'd61,  8'd80};
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        m_ready = 1'b1;

        test_reset();
        test_clean_sweep();
        test_lower_half();
        test_glitch();
        test_lock_loss();
        test_back_pressure();
        test_reset_midstream();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
